pll_reconfig_ctrl: RTL

- Sequences the board PLL (PLLE2_ADV) through its DRP port so software/pins can change the CLKOUT0 divide at runtime.
- Owns PLL RST and the SoC reset: the SoC is held in reset until PLL LOCKED has been stable.
- Sits in the FPGA top between the PLL and the Didactic instance. Runs on the PLL input clock, not the generated clock; DCLK = clk_in.

---
 rtl/pll_reconfig_ctrl.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// PLLE2_ADV CLKOUT0 divide reconfiguration over DRP, plus PLL/SoC reset sequencing.
// Runs on the PLL input clock; the SoC stays in reset until LOCKED has been stable.
module pll_reconfig_ctrl #(
    parameter int         RST_HOLD_CYCLES    = 16,
    parameter int         LOCK_STABLE_CYCLES = 64,
    parameter int         LOCK_TIMEOUT       = 65535,
    parameter int         DRP_TIMEOUT        = 255,
    parameter logic [6:0] ADDR_REG1          = 7'h08,
    parameter logic [6:0] ADDR_REG2          = 7'h09
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        req,
    input  logic [6:0]  req_div,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        soc_reset
);

    typedef enum logic [3:0] {
        PWRUP_HOLD, IDLE, RST_HOLD,
        RD1, WAIT_RD1, WR1, WAIT_WR1,
        RD2, WAIT_RD2, WR2, WAIT_WR2,
        RELEASE, WAIT_LOCK
    } state_t;

    localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] DRP_LAST    = 16'(DRP_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] stable_reg, stable_next;
    logic [6:0]  div_reg, div_next;
    logic [15:0] rd_data_reg, rd_data_next;
    logic        report_reg, report_next;
    logic        lk_meta_reg, lk_s_reg, lk_prev_reg;
    logic        pll_rst_reg, pll_rst_next;
    logic        soc_reset_reg, soc_reset_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [6:0]  daddr_reg, daddr_next;
    logic        den_reg, den_next;
    logic        dwe_reg, dwe_next;
    logic [15:0] di_reg, di_next;

    logic [5:0]  high_f, low_f;
    logic        edge_f, nocnt_f;
    logic [15:0] reg1_new, reg2_new;
    logic        div_ok;

    assign div_ok = (req_div != 7'd0) && (req_div != 7'h7F);

    // Divide of 1 bypasses the counter; otherwise odd divides use the edge bit.
    always_comb begin
        if (div_reg == 7'd1) begin
            high_f  = 6'd1;
            low_f   = 6'd1;
            edge_f  = 1'b0;
            nocnt_f = 1'b1;
        end else begin
            high_f  = div_reg[6:1];
            low_f   = 6'(div_reg - {1'b0, div_reg[6:1]});
            edge_f  = div_reg[0];
            nocnt_f = 1'b0;
        end
    end

    assign reg1_new = {rd_data_reg[15:12], high_f, low_f};
    assign reg2_new = {rd_data_reg[15:8], edge_f, nocnt_f, rd_data_reg[5:0]};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg     <= PWRUP_HOLD;
            cnt_reg       <= '0;
            stable_reg    <= '0;
            div_reg       <= '0;
            rd_data_reg   <= '0;
            report_reg    <= 1'b0;
            lk_meta_reg   <= 1'b0;
            lk_s_reg      <= 1'b0;
            lk_prev_reg   <= 1'b0;
            pll_rst_reg   <= 1'b1;
            soc_reset_reg <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            daddr_reg     <= '0;
            den_reg       <= 1'b0;
            dwe_reg       <= 1'b0;
            di_reg        <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            stable_reg    <= stable_next;
            div_reg       <= div_next;
            rd_data_reg   <= rd_data_next;
            report_reg    <= report_next;
            lk_meta_reg   <= pll_locked;
            lk_s_reg      <= lk_meta_reg;
            lk_prev_reg   <= lk_s_reg;
            pll_rst_reg   <= pll_rst_next;
            soc_reset_reg <= soc_reset_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            daddr_reg     <= daddr_next;
            den_reg       <= den_next;
            dwe_reg       <= dwe_next;
            di_reg        <= di_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        stable_next    = stable_reg;
        div_next       = div_reg;
        rd_data_next   = rd_data_reg;
        report_next    = report_reg;
        pll_rst_next   = pll_rst_reg;
        soc_reset_next = soc_reset_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        daddr_next     = daddr_reg;
        den_next       = 1'b0;
        dwe_next       = 1'b0;
        di_next        = di_reg;

        unique case (state_reg)
            PWRUP_HOLD: begin
                cnt_next = cnt_reg + 16'd1;
                if (cnt_reg == HOLD_LAST) begin
                    pll_rst_next = 1'b0;
                    report_next  = 1'b0;
                    cnt_next     = '0;
                    stable_next  = '0;
                    state_next   = WAIT_LOCK;
                end
            end
            IDLE: begin
                if (req && div_ok) begin
                    err_next       = 1'b0;
                    soc_reset_next = 1'b1;
                    pll_rst_next   = 1'b1;
                    div_next       = req_div;
                    report_next    = 1'b1;
                    cnt_next       = '0;
                    state_next     = RST_HOLD;
                end else if (req) begin
                    err_next  = 1'b1;
                    done_next = 1'b1;
                end else if (lk_prev_reg && !lk_s_reg && !pll_rst_reg) begin
                    // Lock lost on its own: hold the SoC and wait for relock silently.
                    soc_reset_next = 1'b1;
                    report_next    = 1'b0;
                    cnt_next       = '0;
                    stable_next    = '0;
                    state_next     = WAIT_LOCK;
                end
            end
            RST_HOLD: begin
                cnt_next = cnt_reg + 16'd1;
                if (cnt_reg == HOLD_LAST) begin
                    state_next = RD1;
                end
            end
            RD1, RD2: begin
                den_next   = 1'b1;
                daddr_next = (state_reg == RD1) ? ADDR_REG1 : ADDR_REG2;
                cnt_next   = '0;
                state_next = (state_reg == RD1) ? WAIT_RD1 : WAIT_RD2;
            end
            WR1, WR2: begin
                den_next   = 1'b1;
                dwe_next   = 1'b1;
                daddr_next = (state_reg == WR1) ? ADDR_REG1 : ADDR_REG2;
                di_next    = (state_reg == WR1) ? reg1_new : reg2_new;
                cnt_next   = '0;
                state_next = (state_reg == WR1) ? WAIT_WR1 : WAIT_WR2;
            end
            WAIT_RD1, WAIT_WR1, WAIT_RD2, WAIT_WR2: begin
                cnt_next = cnt_reg + 16'd1;
                if (drp_drdy) begin
                    rd_data_next = drp_do;
                    unique case (state_reg)
                        WAIT_RD1: state_next = WR1;
                        WAIT_WR1: state_next = RD2;
                        WAIT_RD2: state_next = WR2;
                        default:  state_next = RELEASE;
                    endcase
                end else if (cnt_reg == DRP_LAST) begin
                    // PLL is left in reset until software retries.
                    err_next       = 1'b1;
                    done_next      = 1'b1;
                    pll_rst_next   = 1'b1;
                    soc_reset_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            RELEASE: begin
                pll_rst_next = 1'b0;
                cnt_next     = '0;
                stable_next  = '0;
                state_next   = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_next    = cnt_reg + 16'd1;
                stable_next = lk_s_reg ? stable_reg + 16'd1 : 16'd0;
                if (lk_s_reg && stable_reg == STABLE_LAST) begin
                    soc_reset_next = 1'b0;
                    done_next      = report_reg;
                    state_next     = IDLE;
                end else if (cnt_reg == LOCK_LAST) begin
                    err_next       = 1'b1;
                    done_next      = 1'b1;
                    soc_reset_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = PWRUP_HOLD;
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign err       = err_reg;
    assign drp_daddr = daddr_reg;
    assign drp_den   = den_reg;
    assign drp_dwe   = dwe_reg;
    assign drp_di    = di_reg;
    assign pll_rst   = pll_rst_reg;
    assign soc_reset = soc_reset_reg;

endmodule
